// File: rtl/cordic_engine.sv
// -----------------------------------------------------------------------------
// cordic_engine
//
// Fully pipelined CORDIC core. Each sample selects, through mode_i, either
// vectoring (magnitude and atan2 of (x, y)) or rotation (rotate (x, y) by z).
// All four quadrants are covered by a quadrant pre-rotation stage. Flow control
// is valid/ready with a single global advance enable, so a downstream stall
// freezes every stage, bubbles included, and preserves sample order.
//
// Optional feature macro: CORDIC_GAIN_COMP_EN
//   defined   : a final stage multiplies x/y by 1/K (true magnitude/rotation),
//               latency STAGES+2.
//   undefined : no multiplier, x/y carry the CORDIC gain K (~1.6468),
//               latency STAGES+1.
//
// Ports
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   valid_i  : input sample valid
//   ready_o  : engine accepts the input sample this cycle
//   mode_i   : 0 = vectoring, 1 = rotation
//   x_i, y_i : signed Q(Q_I).(Q_F) input vector
//   z_i      : signed binary angle (-pi..pi), used in rotation mode only
//   valid_o  : output sample valid
//   ready_i  : downstream accepts the output sample
//   mode_o   : mode of the output sample
//   x_o, y_o : signed, saturated result vector
//   z_o      : signed angle result (atan2 or residual)
// -----------------------------------------------------------------------------
module cordic_engine #(
    parameter int Q_I     = 15,
    parameter int Q_F     = 16,
    parameter int WIDTH   = Q_I + Q_F + 1,
    parameter int ANGLE_W = 32,
    parameter int STAGES  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic                      mode_i,
    input  logic signed [WIDTH-1:0]   x_i,
    input  logic signed [WIDTH-1:0]   y_i,
    input  logic signed [ANGLE_W-1:0] z_i,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      mode_o,
    output logic signed [WIDTH-1:0]   x_o,
    output logic signed [WIDTH-1:0]   y_o,
    output logic signed [ANGLE_W-1:0] z_o
);

    // Elaboration-time parameter checks
    if (WIDTH != Q_I + Q_F + 1 || WIDTH >= 64) begin : g_bad_width
        $error("cordic_engine: WIDTH must equal Q_I+Q_F+1 and be below 64");
    end
    if (ANGLE_W < 8 || ANGLE_W > 32) begin : g_bad_angle_w
        $error("cordic_engine: ANGLE_W must be within 8..32");
    end
    if (STAGES < 4 || STAGES > 31) begin : g_bad_stages
        $error("cordic_engine: STAGES must be within 4..31");
    end

    // Two guard bits absorb the sqrt(2)*K growth of the iterations.
    localparam int IW = WIDTH + 2;

`ifdef CORDIC_GAIN_COMP_EN
    // Register index of the last iteration result (feeds the gain stage).
    localparam int LAST = STAGES;
`else
    // The last iteration feeds the output registers directly.
    localparam int LAST = STAGES - 1;
`endif

    localparam logic signed [ANGLE_W-1:0] HALF_PI     = {2'b01, {(ANGLE_W-2){1'b0}}};
    localparam logic signed [ANGLE_W-1:0] NEG_HALF_PI = {2'b11, {(ANGLE_W-2){1'b0}}};

    // atan(2^-i) / pi * 2^31
    localparam logic [31:0] ATAN_TAB [0:31] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };

    // Top ANGLE_W bits of a table entry, rounded to nearest.
    function automatic logic signed [ANGLE_W-1:0] atan_f(input int idx);
        logic [32:0] r;
        int          sh;
        sh = 32 - ANGLE_W;
        r  = {1'b0, ATAN_TAB[idx]};
        if (sh > 0) begin
            r = r + (33'd1 << (sh - 1));
        end else begin
            r = r;
        end
        r = r >> sh;
        return r[ANGLE_W-1:0];
    endfunction

    // Clamp a (WIDTH+3)-bit signed value to the WIDTH-bit signed range.
    function automatic logic signed [WIDTH-1:0] sat_f(input logic signed [IW:0] v);
        if ((&v[IW:WIDTH-1]) || ~(|v[IW:WIDTH-1])) begin
            return v[WIDTH-1:0];
        end else if (v[IW]) begin
            return {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, {(WIDTH-1){1'b1}}};
        end
    endfunction

    // Pipeline registers: index 0 = pre-rotation, index k = after iteration k-1.
    logic signed [IW-1:0]      x_q [0:LAST];
    logic signed [IW-1:0]      y_q [0:LAST];
    logic signed [ANGLE_W-1:0] z_q [0:LAST];
    logic [LAST:0]             v_q;
    logic [LAST:0]             m_q;

    logic signed [IW-1:0]      pre_x_d, pre_y_d;
    logic signed [ANGLE_W-1:0] pre_z_d;
    logic signed [IW-1:0]      it_x_d [0:STAGES-1];
    logic signed [IW-1:0]      it_y_d [0:STAGES-1];
    logic signed [ANGLE_W-1:0] it_z_d [0:STAGES-1];

    logic signed [WIDTH-1:0]   out_x_d, out_y_d;
    logic signed [ANGLE_W-1:0] out_z_d;
    logic                      out_v_d, out_m_d;

    logic                      valid_q, mode_q;
    logic signed [WIDTH-1:0]   x_out_q, y_out_q;
    logic signed [ANGLE_W-1:0] z_out_q;

    logic                      adv_s;
    logic signed [IW-1:0]      xe_s, ye_s;

    // Global advance: every stage moves unless a valid output is being held.
    assign adv_s   = ready_i | ~valid_q;
    assign ready_o = adv_s;

    assign xe_s = IW'(x_i);
    assign ye_s = IW'(y_i);

    // Quadrant pre-rotation into the +/-pi/2 convergence range
    always_comb begin
        pre_x_d = xe_s;
        pre_y_d = ye_s;
        pre_z_d = '0;
        if (!mode_i) begin
            if (!xe_s[IW-1]) begin
                pre_x_d = xe_s;
                pre_y_d = ye_s;
                pre_z_d = '0;
            end else if (!ye_s[IW-1]) begin
                pre_x_d = ye_s;
                pre_y_d = -xe_s;
                pre_z_d = HALF_PI;
            end else begin
                pre_x_d = -ye_s;
                pre_y_d = xe_s;
                pre_z_d = NEG_HALF_PI;
            end
        end else begin
            if (z_i > HALF_PI) begin
                pre_x_d = -ye_s;
                pre_y_d = xe_s;
                pre_z_d = z_i - HALF_PI;
            end else if (z_i < NEG_HALF_PI) begin
                pre_x_d = ye_s;
                pre_y_d = -xe_s;
                pre_z_d = z_i + HALF_PI;
            end else begin
                pre_x_d = xe_s;
                pre_y_d = ye_s;
                pre_z_d = z_i;
            end
        end
    end

    // CORDIC micro-rotations; direction from sign(y) (vectoring) or sign(z) (rotation)
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            // Counter-clockwise when driving a negative y up or a positive z down.
            if (m_q[i] ? ~z_q[i][ANGLE_W-1] : y_q[i][IW-1]) begin
                it_x_d[i] = x_q[i] - (y_q[i] >>> i);
                it_y_d[i] = y_q[i] + (x_q[i] >>> i);
                it_z_d[i] = z_q[i] - atan_f(i);
            end else begin
                it_x_d[i] = x_q[i] + (y_q[i] >>> i);
                it_y_d[i] = y_q[i] - (x_q[i] >>> i);
                it_z_d[i] = z_q[i] + atan_f(i);
            end
        end
    end

    // Pre-rotation and iteration pipeline registers, frozen while stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k <= LAST; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                z_q[k] <= '0;
            end
            v_q <= '0;
            m_q <= '0;
        end else if (adv_s) begin
            x_q[0] <= pre_x_d;
            y_q[0] <= pre_y_d;
            z_q[0] <= pre_z_d;
            v_q[0] <= valid_i;
            m_q[0] <= mode_i;
            for (int k = 1; k <= LAST; k++) begin
                x_q[k] <= it_x_d[k-1];
                y_q[k] <= it_y_d[k-1];
                z_q[k] <= it_z_d[k-1];
                v_q[k] <= v_q[k-1];
                m_q[k] <= m_q[k-1];
            end
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    localparam int PW = IW + Q_F + 1;

    // 1/K in Q0.32, rescaled to Q0.(Q_F) with round-to-nearest.
    function automatic logic [63:0] kinv_f();
        logic [63:0] c;
        c = 64'd2608131496;
        if (Q_F < 32) begin
            return (c + (64'd1 << (31 - Q_F))) >> (32 - Q_F);
        end else begin
            return c << (Q_F - 32);
        end
    endfunction

    localparam logic signed [Q_F:0] KINV = {1'b0, Q_F'(kinv_f())};

    logic signed [PW-1:0] prod_x_s, prod_y_s;

    // Gain compensation: multiply by 1/K, arithmetic shift back by Q_F, saturate
    always_comb begin
        prod_x_s = PW'(x_q[STAGES]) * PW'(KINV);
        prod_y_s = PW'(y_q[STAGES]) * PW'(KINV);
        out_x_d  = sat_f((IW + 1)'(prod_x_s >>> Q_F));
        out_y_d  = sat_f((IW + 1)'(prod_y_s >>> Q_F));
        out_z_d  = z_q[STAGES];
        out_v_d  = v_q[STAGES];
        out_m_d  = m_q[STAGES];
    end
`else
    // Uncompensated: saturate the last iteration result straight into the outputs
    always_comb begin
        out_x_d = sat_f((IW + 1)'(it_x_d[STAGES-1]));
        out_y_d = sat_f((IW + 1)'(it_y_d[STAGES-1]));
        out_z_d = it_z_d[STAGES-1];
        out_v_d = v_q[LAST];
        out_m_d = m_q[LAST];
    end
`endif

    // Output registers, held stable while the downstream stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
            z_out_q <= '0;
        end else if (adv_s) begin
            valid_q <= out_v_d;
            mode_q  <= out_m_d;
            x_out_q <= out_x_d;
            y_out_q <= out_y_d;
            z_out_q <= out_z_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign x_o     = x_out_q;
    assign y_o     = y_out_q;
    assign z_o     = z_out_q;

endmodule

// File: tb/tb_cordic_engine.sv
// -----------------------------------------------------------------------------
// tb_cordic_engine
//
// Directed self-checking bench for cordic_engine with Q_I=15, Q_F=16,
// ANGLE_W=32, STAGES=16. Expected values are hand-derived reals scaled to
// Q16; without CORDIC_GAIN_COMP_EN they carry the CORDIC gain K.
// -----------------------------------------------------------------------------
module tb_cordic_engine;

    logic                clk_i   = 1'b0;
    logic                rst_ni  = 1'b0;
    logic                valid_i = 1'b0;
    logic                ready_i = 1'b1;
    logic                mode_i  = 1'b0;
    logic signed [31:0]  x_i     = '0;
    logic signed [31:0]  y_i     = '0;
    logic signed [31:0]  z_i     = '0;
    logic                ready_o;
    logic                valid_o;
    logic                mode_o;
    logic signed [31:0]  x_o;
    logic signed [31:0]  y_o;
    logic signed [31:0]  z_o;

`ifdef CORDIC_GAIN_COMP_EN
    localparam real GAIN = 1.0;
    localparam int  LAT  = 18;
    localparam int  TOL  = 16;
`else
    localparam real GAIN = 1.6467602;
    localparam int  LAT  = 17;
    localparam int  TOL  = 32;
`endif

    localparam int ZTOL = 65536;

    int total = 0;
    int bad   = 0;

    cordic_engine #(
        .Q_I(15), .Q_F(16), .WIDTH(32), .ANGLE_W(32), .STAGES(16)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .mode_i (mode_i),
        .x_i    (x_i),
        .y_i    (y_i),
        .z_i    (z_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .mode_o (mode_o),
        .x_o    (x_o),
        .y_o    (y_o),
        .z_o    (z_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int q16(input real v);
        return int'(v * GAIN * 65536.0);
    endfunction

    task automatic chk_eq(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tol(input string tag, input longint obs, input longint exp, input longint tol);
        total++;
        assert ((obs >= exp - tol) && (obs <= exp + tol)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    // One isolated sample; returns at the negedge where valid_o is first seen.
    task automatic one_shot(input logic m, input logic signed [31:0] x, input logic signed [31:0] y,
                            input logic signed [31:0] z, output int lat);
        @(posedge clk_i); #1;
        valid_i = 1'b1; mode_i = m; x_i = x; y_i = y; z_i = z;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        lat = 1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_i);
            if (valid_o) break;
            lat++;
        end
    endtask

    int                 lat;
    int                 in_idx;
    int                 out_idx;
    int                 cyc;
    logic               prev_stall;
    logic signed [31:0] hx, hy, hz;
    logic               hm;
    int                 exp_x [20];
    logic               exp_m [20];

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk_eq("rst_valid_o", valid_o, 0);
        chk_eq("rst_ready_o", ready_o, 1);
        chk_eq("rst_x_o", x_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Vectoring (3,4)
        one_shot(1'b0, 32'sh00030000, 32'sh00040000, 32'sh0, lat);
        chk_eq("vec34_latency", lat, LAT);
        chk_tol("vec34_x", x_o, q16(5.0), TOL);
        chk_tol("vec34_z", z_o, 64'sd633866800, ZTOL);

        // Rotation (1,0) by pi/4
        one_shot(1'b1, 32'sh00010000, 32'sh0, 32'sh20000000, lat);
        chk_tol("rot45_x", x_o, q16(0.70710678), TOL);
        chk_tol("rot45_y", y_o, q16(0.70710678), TOL);

        // Vectoring (-1,-1): third quadrant
        one_shot(1'b0, -32'sh00010000, -32'sh00010000, 32'sh0, lat);
        chk_tol("vecq3_x", x_o, q16(1.41421356), TOL);
        chk_tol("vecq3_z", z_o, -64'sd1610612736, ZTOL);

        // Rotation (1,0) by 7pi/8: beyond +pi/2
        one_shot(1'b1, 32'sh00010000, 32'sh0, 32'sh70000000, lat);
        chk_tol("rot7pi8_x", x_o, q16(-0.92387953), TOL);
        chk_tol("rot7pi8_y", y_o, q16(0.38268343), TOL);

        // Saturation of an oversize magnitude
        one_shot(1'b0, 32'sh7FFFFFFF, 32'sh7FFFFFFF, 32'sh0, lat);
        chk_eq("sat_x", x_o, 64'sd2147483647);

        // Mixed stream of 20 samples with a 5-cycle downstream stall
        for (int k = 0; k < 20; k++) begin
            exp_m[k] = k[0];
            exp_x[k] = k[0] ? q16(1.0 * (k + 1)) : q16(5.0 * (k + 1));
        end
        in_idx = 0; out_idx = 0; cyc = 0; prev_stall = 1'b0;
        hx = '0; hy = '0; hz = '0; hm = 1'b0;
        @(posedge clk_i); #1;
        while (out_idx < 20 && cyc < 300) begin
            ready_i = !(cyc >= 18 && cyc <= 22);
            valid_i = (in_idx < 20);
            mode_i  = in_idx[0];
            x_i     = in_idx[0] ? 32'((in_idx + 1) * 65536) : 32'((in_idx + 1) * 3 * 65536);
            y_i     = in_idx[0] ? 32'sh0 : 32'((in_idx + 1) * 4 * 65536);
            z_i     = 32'sh0;
            @(negedge clk_i);
            if (prev_stall) begin
                chk_eq("hold_valid", valid_o, 1);
                chk_eq("hold_x", x_o, hx);
                chk_eq("hold_y", y_o, hy);
                chk_eq("hold_z", z_o, hz);
                chk_eq("hold_mode", mode_o, hm);
            end
            if (valid_o && !ready_i) begin
                chk_eq("stall_ready_o", ready_o, 0);
                prev_stall = 1'b1;
                hx = x_o; hy = y_o; hz = z_o; hm = mode_o;
            end else begin
                prev_stall = 1'b0;
            end
            if (valid_o && ready_i) begin
                chk_tol("stream_x", x_o, exp_x[out_idx], TOL);
                chk_eq("stream_mode", mode_o, exp_m[out_idx]);
                out_idx++;
            end
            if (valid_i && ready_o) in_idx++;
            @(posedge clk_i); #1;
            cyc++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        chk_eq("stream_count", out_idx, 20);

        // Asynchronous reset with the pipeline full and stalled
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        valid_i = 1'b1; mode_i = 1'b1; x_i = 32'sh00010000; y_i = 32'sh0; z_i = 32'sh20000000;
        repeat (25) @(posedge clk_i);
        #1;
        chk_eq("full_valid_o", valid_o, 1);
        chk_eq("full_ready_o", ready_o, 0);
        #1;
        rst_ni = 1'b0;
        #1;
        chk_eq("arst_valid_o", valid_o, 0);
        chk_eq("arst_x_o", x_o, 0);
        chk_eq("arst_y_o", y_o, 0);
        chk_eq("arst_z_o", z_o, 0);
        chk_eq("arst_mode_o", mode_o, 0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;

        // First sample after reset
        one_shot(1'b0, 32'sh00030000, 32'sh00040000, 32'sh0, lat);
        chk_eq("post_rst_latency", lat, LAT);
        chk_tol("post_rst_x", x_o, q16(5.0), TOL);

        @(posedge clk_i); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
